// File: rtl/perm_pkg.sv
// Shared types and helpers for the bit permutation pipeline.
// The mode travels with each word, so a stream can mix fixed and table-driven routing.
package perm_pkg;

  localparam int unsigned MaxWidth = 64;

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    REV      = 2'd1,
    MAP      = 2'd2,
    MAP_MASK = 2'd3
  } mode_e;

  // Operates on a right-aligned MaxWidth container so one helper serves any WIDTH <= MaxWidth.
  function automatic logic [MaxWidth-1:0] reverse_bits(input logic [MaxWidth-1:0] a,
                                                       input int unsigned       width);
    logic [MaxWidth-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i < width) r[i] = a[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_permute_pipe_if.sv
// Stream and table-write signals of the bit permutation pipeline.
// master drives words and table writes; slave is the pipeline itself.
interface bit_permute_pipe_if
  import perm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] in_mask;
  mode_e            in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [IDX_W-1:0] cfg_src;
  logic             cfg_ready;

  modport master (
    output in_valid, in_data, in_mask, in_mode, out_ready, cfg_we, cfg_idx, cfg_src,
    input  in_ready, out_valid, out_data, cfg_ready
  );

  modport slave (
    input  in_valid, in_data, in_mask, in_mode, out_ready, cfg_we, cfg_idx, cfg_src,
    output in_ready, out_valid, out_data, cfg_ready
  );

endinterface

// File: rtl/perm_map_table.sv
// Source-index map table: identity after reset, one entry written per accepted request,
// with a registered flag telling whether the table is currently a bijection.
module perm_map_table
  import perm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [IDX_W-1:0]       src,
  output logic [WIDTH*IDX_W-1:0] map_flat,
  output logic                   perm_ok
);

  localparam int unsigned Slots = 2 ** IDX_W;

  logic [IDX_W-1:0] map_q [WIDTH];
  logic [Slots-1:0] in_range;
  logic [WIDTH-1:0] used;
  logic             perm_ok_q;

  // Writes naming a bit beyond WIDTH (non power-of-two widths only) are dropped.
  always_comb begin
    in_range = '0;
    for (int unsigned k = 0; k < Slots; k++) in_range[k] = (k < WIDTH);
  end

  always_comb begin
    used = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned s = 0; s < WIDTH; s++) begin
        if (map_q[i] == IDX_W'(s)) used[s] = 1'b1;
      end
    end
  end

  always_comb begin
    map_flat = '0;
    for (int unsigned i = 0; i < WIDTH; i++) map_flat[i*IDX_W +: IDX_W] = map_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) map_q[i] <= IDX_W'(i);
      perm_ok_q <= 1'b1;
    end else begin
      if (we && in_range[idx] && in_range[src]) map_q[idx] <= src;
      perm_ok_q <= &used;
    end
  end

  assign perm_ok = perm_ok_q;

endmodule

// File: rtl/bit_permute_pipe.sv
// Two-stage valid/ready bit permutation pipeline: S1 holds the accepted word, S2 the result.
// Table writes are only taken with both stages empty, so no in-flight word sees a table change.
module bit_permute_pipe
  import perm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH),
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  bit_permute_pipe_if.slave bus,
  output logic              perm_ok,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic                   s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]       s1_data_q, s1_data_d;
  logic [WIDTH-1:0]       s1_mask_q, s1_mask_d;
  mode_e                  s1_mode_q, s1_mode_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH*IDX_W-1:0] map_flat;
  logic [WIDTH-1:0]       rev;
  logic [WIDTH-1:0]       perm;
  logic [IDX_W-1:0]       src;
  logic                   s2_advance, cfg_fire, in_fire, out_fire;

  assign s2_advance    = !out_valid_q || bus.out_ready;
  assign bus.cfg_ready = !s1_valid_q && !out_valid_q;
  assign cfg_fire      = bus.cfg_we && bus.cfg_ready;
  // A table write wins over a word offered in the same cycle.
  assign bus.in_ready  = (!s1_valid_q || s2_advance) && !cfg_fire;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = out_valid_q && bus.out_ready;

  perm_map_table #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_map_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (cfg_fire),
    .idx      (bus.cfg_idx),
    .src      (bus.cfg_src),
    .map_flat (map_flat),
    .perm_ok  (perm_ok)
  );

  always_comb begin
    rev  = WIDTH'(reverse_bits(MaxWidth'(s1_data_q), WIDTH));
    perm = '0;
    src  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      src = map_flat[i*IDX_W +: IDX_W];
      case (s1_mode_q)
        PASS:     perm[i] = s1_data_q[i];
        REV:      perm[i] = rev[i];
        MAP:      perm[i] = s1_data_q[src];
        MAP_MASK: perm[i] = s1_data_q[src] & s1_mask_q[i];
      endcase
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_mask_d   = s1_mask_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = bus.in_data;
      s1_mask_d  = bus.in_mask;
      s1_mode_d  = bus.in_mode;
    end else if (s2_advance) begin
      s1_valid_d = 1'b0;
    end
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_data_d = perm;
    end
    cnt_d = cnt_q + CNT_W'(out_fire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mask_q   <= '0;
      s1_mode_q   <= PASS;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_mask_q   <= s1_mask_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign xfer_cnt      = cnt_q;

endmodule
